// File: rtl/sie_rx.sv
// sie_rx: receive-side packet decoder of the USB full-speed Serial Interface
// Engine. Consumes the PHY byte/valid/err/ready event stream. It checks PID
// check bits, CRC5 (tokens) and CRC16 (data), extracts the token fields, and
// streams the data payload with the two trailing CRC bytes stripped. Exactly
// one verdict pulse is produced per packet.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   clk_gate_i           one-cycle enable per bit time; all state moves on it
//   rx_data_i[7:0]       PHY byte, LSB received first
//   rx_valid_i/rx_err_i  byte present / PHY abort, qualified by rx_ready_i
//   rx_ready_i           PHY event strobe (valid=0, err=0 means EOP)
//   bus_reset_i          USB bus reset / detach, returns decoder to idle
//   pid_o, addr_o, endp_o, frame_o   held packet fields
//   data_o, data_valid_o payload byte stream
//   token_ok_o, data_ok_o, hsk_ok_o, pkt_err_o   per-packet verdict pulses
module sie_rx (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clk_gate_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_err_i,
  input  logic        rx_ready_i,
  input  logic        bus_reset_i,
  output logic [3:0]  pid_o,
  output logic [6:0]  addr_o,
  output logic [3:0]  endp_o,
  output logic [10:0] frame_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        token_ok_o,
  output logic        data_ok_o,
  output logic        hsk_ok_o,
  output logic        pkt_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_DATA,
    ST_HSK,
    ST_DISCARD
  } state_t;

  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [4:0]  CRC5_GOOD  = 5'b01100;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_GOOD = 16'h800D;
  localparam logic [10:0] CNT_MAX    = 11'd2047;

  // Bits enter LSB first, matching the order they came off the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  state_t      state_q;
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic [10:0] cnt_q;
  logic [7:0]  b1_q;
  logic [2:0]  b2_q;
  logic [7:0]  byte_p0;
  logic [7:0]  byte_p1;
  logic        pid_good;

  assign pid_good = (rx_data_i[7:4] == ~rx_data_i[3:0]);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      crc5_q       <= CRC5_INIT;
      crc16_q      <= CRC16_INIT;
      cnt_q        <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      byte_p0      <= '0;
      byte_p1      <= '0;
      pid_o        <= '0;
      addr_o       <= '0;
      endp_o       <= '0;
      frame_o      <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      token_ok_o   <= 1'b0;
      data_ok_o    <= 1'b0;
      hsk_ok_o     <= 1'b0;
      pkt_err_o    <= 1'b0;
    end else if (clk_gate_i) begin
      data_valid_o <= 1'b0;
      token_ok_o   <= 1'b0;
      data_ok_o    <= 1'b0;
      hsk_ok_o     <= 1'b0;
      pkt_err_o    <= 1'b0;
      if (bus_reset_i) begin
        // Reset wins over any coincident byte; held fields are kept.
        state_q <= ST_IDLE;
        crc5_q  <= CRC5_INIT;
        crc16_q <= CRC16_INIT;
        cnt_q   <= '0;
        byte_p0 <= '0;
        byte_p1 <= '0;
      end else if (rx_ready_i) begin
        if (rx_err_i) begin
          // PHY abort in any state ends the packet; undelivered bytes are lost.
          pkt_err_o <= 1'b1;
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          byte_p0   <= '0;
          byte_p1   <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rx_valid_i) begin
                crc5_q  <= CRC5_INIT;
                crc16_q <= CRC16_INIT;
                cnt_q   <= '0;
                if (!pid_good || rx_data_i[1:0] == 2'b00) begin
                  state_q <= ST_DISCARD;
                end else begin
                  pid_o <= rx_data_i[3:0];
                  case (rx_data_i[1:0])
                    2'b01:   state_q <= ST_TOKEN;
                    2'b11:   state_q <= ST_DATA;
                    default: state_q <= ST_HSK;
                  endcase
                end
              end else begin
                pkt_err_o <= 1'b1;
              end
            end
            ST_TOKEN: begin
              if (rx_valid_i) begin
                if (cnt_q == 11'd2) begin
                  state_q <= ST_DISCARD;
                end else begin
                  crc5_q <= crc5_byte(crc5_q, rx_data_i);
                  cnt_q  <= cnt_q + 11'd1;
                  if (cnt_q == 11'd0) b1_q <= rx_data_i;
                  else                b2_q <= rx_data_i[2:0];
                end
              end else begin
                if (cnt_q == 11'd2 && crc5_q == CRC5_GOOD) begin
                  addr_o     <= b1_q[6:0];
                  endp_o     <= {b2_q, b1_q[7]};
                  frame_o    <= {b2_q, b1_q};
                  token_ok_o <= 1'b1;
                end else begin
                  pkt_err_o <= 1'b1;
                end
                state_q <= ST_IDLE;
              end
            end
            ST_DATA: begin
              if (rx_valid_i) begin
                crc16_q <= crc16_byte(crc16_q, rx_data_i);
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 11'd1;
                // Two-byte delay line: a byte is released only once two newer
                // bytes prove it is not part of the CRC16 trailer.
                byte_p0 <= rx_data_i;
                byte_p1 <= byte_p0;
                if (cnt_q >= 11'd2) begin
                  data_o       <= byte_p1;
                  data_valid_o <= 1'b1;
                end
              end else begin
                if (cnt_q >= 11'd2 && crc16_q == CRC16_GOOD) data_ok_o <= 1'b1;
                else                                         pkt_err_o <= 1'b1;
                state_q <= ST_IDLE;
              end
            end
            ST_HSK: begin
              if (rx_valid_i) begin
                state_q <= ST_DISCARD;
              end else begin
                hsk_ok_o <= 1'b1;
                state_q  <= ST_IDLE;
              end
            end
            ST_DISCARD: begin
              if (!rx_valid_i) begin
                pkt_err_o <= 1'b1;
                state_q   <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/sie_rx.md
# sie_rx

Receive-side packet decoder of the Serial Interface Engine (SIE). It sits directly downstream of the USB full-speed PHY receiver and consumes its byte/valid/err/ready stream. It validates PID check bits, CRC5 and CRC16, extracts token fields, and streams data payload with the two CRC bytes stripped. It reports exactly one end-of-packet verdict per received packet.

## Interface
Parameters:
- none (timing set by `clk_gate_i`; clk_i = 12MHz × BIT_SAMPLES in the PHY)

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous, active-low reset
- clk_gate_i  in  1  one-clk_i-wide enable, once per bit time; all state updates only when high
- rx_data_i  in  8  byte from PHY, LSB = first received bit
- rx_valid_i  in  1  byte present (qualified by rx_ready_i)
- rx_err_i  in  1  PHY abort (qualified by rx_ready_i)
- rx_ready_i  in  1  PHY event strobe; valid=0 and err=0 means EOP
- bus_reset_i  in  1  USB bus reset / detach
- pid_o  out  4  PID of last accepted packet, held until next PID
- addr_o  out  7  token address, held
- endp_o  out  4  token endpoint, held
- frame_o  out  11  SOF frame number, held
- data_o  out  8  payload byte
- data_valid_o  out  1  data_o valid, one gated period
- token_ok_o  out  1  valid token (OUT/IN/SETUP/SOF) received
- data_ok_o  out  1  data packet ended with good CRC16
- hsk_ok_o  out  1  valid handshake (ACK/NAK/STALL/NYET) received
- pkt_err_o  out  1  packet rejected

## Operation
- An event is consumed only on a clk_i edge where clk_gate_i & rx_ready_i are both high.
- States: ST_IDLE, ST_TOKEN, ST_DATA, ST_HSK, ST_DISCARD.
- ST_IDLE, byte event: PID check requires rx_data_i[7:4] == ~rx_data_i[3:0].
  - If the check fails, or the PID type is special (pid[1:0]=00): go to ST_DISCARD.
  - Otherwise store pid_o = rx_data_i[3:0] and branch by pid[1:0]: 01 → ST_TOKEN, 11 → ST_DATA, 10 → ST_HSK.
- ST_IDLE, EOP or err event: pulse pkt_err_o and stay in ST_IDLE.
- ST_TOKEN: accepts exactly 2 bytes b1, b2.
  - CRC5 runs over all 16 bits in received order: init 5'b11111; per bit x: fb = x^c[4]; c = {c[3:0],0} ^ (fb ? 5'b00101 : 0).
  - Good residual is 5'b01100.
  - On EOP with count==2 and residual good: addr_o=b1[6:0], endp_o={b2[2:0],b1[7]}, frame_o={b2[2:0],b1}, pulse token_ok_o.
  - Any other count, or a bad residual: pulse pkt_err_o. A 3rd byte → ST_DISCARD.
- ST_DATA: CRC16 runs over every byte after the PID: init 16'hFFFF; fb = x^c[15]; c = {c[14:0],0} ^ (fb ? 16'h8005 : 0). Good residual is 16'h800D.
  - Two-byte delay line: on the kth byte (k≥3), emit byte k-2 on data_o with data_valid_o.
  - On EOP: count≥2 and residual good → data_ok_o, else pkt_err_o.
  - Byte counter saturates at 2047 (no length limit enforced).
- ST_HSK: EOP → hsk_ok_o. Any byte → ST_DISCARD.
- ST_DISCARD: ignore bytes; on EOP or err pulse pkt_err_o, then go to ST_IDLE.
- rx_err_i event in any non-idle state: pulse pkt_err_o, go to ST_IDLE, drop any undelivered delay-line bytes.
- Exactly one of token_ok_o/data_ok_o/hsk_ok_o/pkt_err_o pulses per packet.
- bus_reset_i (sampled on clk_gate_i): force ST_IDLE, clear CRCs, counter and delay line; suppress all pulses that cycle. Held fields keep their values.
- A byte and bus_reset_i in the same gated cycle: the reset wins and the byte is dropped.

## Timing
- Reset values: all pulse outputs 0, pid_o/addr_o/endp_o 0, frame_o 0, data_o 0, state ST_IDLE.
- Outputs are registered and update on the clk_gate_i edge that consumes the event.
- Pulses stay high exactly one gated period (BIT_SAMPLES clk_i cycles) and clear at the next clk_gate_i edge.
- data_valid_o latency: same gated edge as the byte that is 2 positions later in the packet.
- Held fields update on the same edge as token_ok_o; pid_o updates on the PID-byte edge.
- Not updated on a bad token; pid_o still updates if the PID check passed.
- Upstream events are at least 8 gated periods apart, so no input backpressure exists.

## Test plan
- SETUP 2D 00 10, EOP → pid_o=D, addr_o=0, endp_o=0, token_ok_o one pulse, no data_valid_o.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94, EOP → data_o sequence 80 06 00 01 00 00 40 00 (8 pulses, first on byte 3), then data_ok_o.
- Same packet with one payload bit flipped → 8 data_valid_o pulses, then pkt_err_o, no data_ok_o.
- ACK D2, EOP → hsk_ok_o, pid_o=2. Byte 0xD3 (PID check fails) then 2 bytes and EOP → single pkt_err_o, pid_o unchanged.
- DATA0 C3 00 00 (zero length) → data_ok_o, no data_valid_o. rx_err_i after 4 bytes → pkt_err_o, next packet decodes normally.
- bus_reset_i asserted mid-DATA → no pulses; a following 2D 00 10 yields token_ok_o.
